// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem request port, IF/ID register, hold buffer
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic              branch_i,
   input  logic [DATA_W-1:0] branch_target_i,
   output logic              imem_req_o,
   output logic [DATA_W-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [DATA_W-1:0] imem_rdata_i,
   output logic              ifid_valid_o,
   output logic [DATA_W-1:0] ifid_instr_o,
   output logic [DATA_W-1:0] ifid_pc_o,
   output logic [DATA_W-1:0] ifid_pc_plus8_o,
   output logic              fetch_busy_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetched_o,
   output logic [31:0]       perf_stall_o
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} state_t;

   localparam logic [DATA_W-1:0] STEP  = DATA_W'(PC_STEP);
   localparam logic [DATA_W-1:0] EIGHT = DATA_W'(8);

   state_t            state, state_n;
   logic [DATA_W-1:0] pc, pc_n;
   logic [DATA_W-1:0] kill_addr, kill_addr_n;
   logic [DATA_W-1:0] hold_instr, hold_instr_n;
   logic [DATA_W-1:0] hold_pc, hold_pc_n;
   logic              valid_n;
   logic [DATA_W-1:0] instr_n, ipc_n, ip8_n;
   logic [DATA_W-1:0] target;

   assign target = {branch_target_i[DATA_W-1:2], 2'b00};

   // KILL keeps presenting the abandoned address until its ack drains
   assign imem_req_o   = (state == REQ) || (state == KILL);
   assign imem_addr_o  = (state == KILL) ? kill_addr : pc;
   assign fetch_busy_o = imem_req_o;

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      kill_addr_n  = kill_addr;
      hold_instr_n = hold_instr;
      hold_pc_n    = hold_pc;
      valid_n      = ifid_valid_o;
      instr_n      = ifid_instr_o;
      ipc_n        = ifid_pc_o;
      ip8_n        = ifid_pc_plus8_o;
      case (state)
         IDLE: begin
            state_n = REQ;
            if (branch_i) begin
               pc_n    = target;
               valid_n = 1'b0;
            end
         end
         REQ: begin
            if (branch_i) begin
               pc_n    = target;
               valid_n = 1'b0;
               if (!imem_ack_i) begin
                  kill_addr_n = pc;
                  state_n     = KILL;
               end
            end else if (imem_ack_i) begin
               pc_n = pc + STEP;
               if (stall_i && ifid_valid_o) begin
                  hold_instr_n = imem_rdata_i;
                  hold_pc_n    = pc;
                  state_n      = HOLD;
               end else begin
                  valid_n = 1'b1;
                  instr_n = imem_rdata_i;
                  ipc_n   = pc;
                  ip8_n   = pc + EIGHT;
               end
            end
         end
         HOLD: begin
            if (branch_i) begin
               pc_n    = target;
               valid_n = 1'b0;
               state_n = REQ;
            end else if (!stall_i) begin
               valid_n = 1'b1;
               instr_n = hold_instr;
               ipc_n   = hold_pc;
               ip8_n   = hold_pc + EIGHT;
               state_n = REQ;
            end
         end
         KILL: begin
            if (branch_i) begin
               pc_n    = target;
               valid_n = 1'b0;
            end else if (imem_ack_i) begin
               state_n = REQ;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         pc              <= RESET_PC;
         kill_addr       <= '0;
         hold_instr      <= '0;
         hold_pc         <= '0;
         ifid_valid_o    <= 1'b0;
         ifid_instr_o    <= '0;
         ifid_pc_o       <= '0;
         ifid_pc_plus8_o <= '0;
      end else begin
         state           <= state_n;
         pc              <= pc_n;
         kill_addr       <= kill_addr_n;
         hold_instr      <= hold_instr_n;
         hold_pc         <= hold_pc_n;
         ifid_valid_o    <= valid_n;
         ifid_instr_o    <= instr_n;
         ifid_pc_o       <= ipc_n;
         ifid_pc_plus8_o <= ip8_n;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic fetch_load;

   assign fetch_load = (state == REQ && !branch_i && imem_ack_i && !(stall_i && ifid_valid_o))
                    || (state == HOLD && !branch_i && !stall_i);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetched_o <= 32'd0;
         perf_stall_o   <= 32'd0;
      end else begin
         if (fetch_load)
            perf_fetched_o <= perf_fetched_o + 32'd1;
         if (stall_i && ifid_valid_o)
            perf_stall_o <= perf_stall_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a queue-based fetch model
module tb_fetch_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, stall, branch, ack;
   logic [31:0] target, rdata;
   logic        req, valid, busy;
   logic [31:0] addr, instr, ipc, ip8;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall;
`endif

   fetch_stage dut (
      .clk             (clk),
      .reset           (reset),
      .stall_i         (stall),
      .branch_i        (branch),
      .branch_target_i (target),
      .imem_req_o      (req),
      .imem_addr_o     (addr),
      .imem_ack_i      (ack),
      .imem_rdata_i    (rdata),
      .ifid_valid_o    (valid),
      .ifid_instr_o    (instr),
      .ifid_pc_o       (ipc),
      .ifid_pc_plus8_o (ip8),
      .fetch_busy_o    (busy)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched_o  (perf_fetched),
      .perf_stall_o    (perf_stall)
`endif
   );

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   // Model: a fetch is in flight unless one word is parked; a stale flag marks an abandoned request
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } word_t;

   word_t       hold_q[$];
   logic [31:0] m_pc, m_stale_addr, m_instr, m_ipc;
   bit          m_started, m_stale, m_v, m_loaded;
   int unsigned m_fetched, m_stalls;
   bit          use_const;
   logic [31:0] const_word;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3E1};
   endfunction

   function automatic bit exp_req();
      return m_started && (hold_q.size() == 0);
   endfunction

   function automatic logic [31:0] exp_addr();
      return m_stale ? m_stale_addr : m_pc;
   endfunction

   task automatic model_reset();
      hold_q.delete();
      m_pc = 32'h0; m_stale_addr = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
      m_started = 0; m_stale = 0; m_v = 0; m_loaded = 0;
      m_fetched = 0; m_stalls = 0;
   endtask

   task automatic model_load(input word_t w);
      m_v = 1; m_loaded = 1; m_instr = w.instr; m_ipc = w.pc;
      m_fetched++;
   endtask

   task automatic model_step(input bit s, input bit b, input logic [31:0] t, input bit a,
                             input logic [31:0] d);
      logic [31:0] ta;
      word_t       w;
      ta = t & 32'hFFFF_FFFC;
      if (s && m_v) m_stalls++;
      if (!m_started) begin
         m_started = 1;
         if (b) begin m_pc = ta; m_v = 0; end
      end else if (m_stale) begin
         if (b) begin m_pc = ta; m_v = 0; end
         else if (a) m_stale = 0;
      end else if (hold_q.size() != 0) begin
         if (b) begin hold_q.delete(); m_pc = ta; m_v = 0; end
         else if (!s) model_load(hold_q.pop_front());
      end else if (b) begin
         if (!a) begin m_stale = 1; m_stale_addr = m_pc; end
         m_pc = ta; m_v = 0;
      end else if (a) begin
         w.instr = d; w.pc = m_pc;
         if (s && m_v) hold_q.push_back(w);
         else model_load(w);
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic compare_model();
      chk1("req", req, exp_req());
      chk1("busy", busy, exp_req());
      if (exp_req()) chk("addr", addr, exp_addr());
      chk1("valid", valid, m_v);
      chk("instr", instr, m_loaded ? m_instr : 32'h0);
      chk("ifid_pc", ipc, m_loaded ? m_ipc : 32'h0);
      chk("pc_plus8", ip8, m_loaded ? m_ipc + 32'd8 : 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stall", perf_stall, m_stalls);
`endif
   endtask

   task automatic drive(input bit s, input bit b, input logic [31:0] t, input bit a);
      logic [31:0] d;
      d = use_const ? const_word : mem_word(exp_addr());
      stall = s; branch = b; target = t; ack = a; rdata = d;
      model_step(s, b, t, a, d);
   endtask

   task automatic cyc(input bit s, input bit b, input logic [31:0] t, input bit a);
      drive(s, b, t, a);
      @(negedge clk);
      #1;
      compare_model();
   endtask

   // Asynchronous reset between edges; outputs must clear without waiting for a clock
   task automatic do_reset();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk1("rst_req", req, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_valid", valid, 1'b0);
      chk("rst_pc", ipc, 32'h0);
      chk("rst_plus8", ip8, 32'h0);
      stall = 0; branch = 0; ack = 1;
      repeat (2) @(negedge clk);
      #1;
      compare_model();
      reset = 1'b1;
   endtask

   initial begin
      reset = 0; stall = 0; branch = 0; ack = 0; target = 0; rdata = 0;
      use_const = 1; const_word = 32'hE281_1001;
      model_reset();
      @(negedge clk);
      #1;
      compare_model();
      chk("rst_instr", instr, 32'h0);
      reset = 1;

      cyc(0, 0, 0, 1);
      chk1("a_req", req, 1'b1);
      chk("a_addr0", addr, 32'h0);
      cyc(0, 0, 0, 1);
      chk("a_pc0", ipc, 32'h0);
      chk("a_plus8", ip8, 32'h8);
      chk("a_instr", instr, 32'hE281_1001);
      cyc(0, 0, 0, 1);
      chk("a_pc4", ipc, 32'h4);
      cyc(0, 0, 0, 1);
      chk("a_pc8", ipc, 32'h8);
      chk1("a_valid", valid, 1'b1);
      use_const = 0;

      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < 3; w++) begin
            cyc(0, 0, 0, 0);
            chk("b_addr", addr, 32'hC + 32'(4 * k));
            chk1("b_busy", busy, 1'b1);
            chk("b_ifid_hold", ipc, 32'h8 + 32'(4 * k));
         end
         cyc(0, 0, 0, 1);
         chk("b_ifid", ipc, 32'hC + 32'(4 * k));
      end

      cyc(1, 0, 0, 1);
      chk1("c_req", req, 1'b0);
      chk("c_ifid", ipc, 32'h14);
      repeat (4) begin
         cyc(1, 0, 0, 0);
         chk("c_ifid_stall", ipc, 32'h14);
         chk1("c_valid", valid, 1'b1);
      end
      cyc(0, 0, 0, 0);
      chk("c_release", ipc, 32'h18);
      chk("c_instr", instr, mem_word(32'h18));
      chk("c_next_addr", addr, 32'h1C);

      cyc(0, 0, 0, 0);
      cyc(0, 1, 32'h100, 0);
      chk1("d_valid", valid, 1'b0);
      chk("d_old_addr", addr, 32'h1C);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      chk("d_new_addr", addr, 32'h100);
      chk("d_not_written", ipc, 32'h18);
      cyc(0, 0, 0, 1);
      chk("d_target", ipc, 32'h100);

      cyc(1, 0, 0, 1);
      chk1("e_hold_req", req, 1'b0);
      cyc(1, 1, 32'h43, 0);
      chk1("e_valid", valid, 1'b0);
      chk("e_addr", addr, 32'h40);
      cyc(1, 0, 0, 1);
      chk("e_ifid", ipc, 32'h40);

      drive(0, 0, 0, 0);
      do_reset();
      cyc(0, 0, 0, 1);
      chk("f_restart", addr, 32'h0);
      chk1("f_valid", valid, 1'b0);
      cyc(0, 0, 0, 1);
      chk("f_first", ipc, 32'h0);

      cyc(0, 1, 32'hFFFF_FFFF, 1);
      chk("g_addr", addr, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 1);
      chk("g_pc", ipc, 32'hFFFF_FFFC);
      chk("g_plus8", ip8, 32'h4);
      chk("g_wrap", addr, 32'h0);

`ifdef FETCH_PERF_CNT_EN
      drive(0, 0, 0, 0);
      do_reset();
      cyc(0, 0, 0, 1);
      repeat (10) cyc(0, 0, 0, 1);
      repeat (3) cyc(1, 0, 0, 0);
      chk("p_fetched", perf_fetched, 32'd10);
      chk("p_stall", perf_stall, 32'd3);
      cyc(0, 0, 0, 0);
`endif

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(999) < 3) begin
            drive(0, 0, 0, $urandom_range(1));
            do_reset();
         end
         cyc($urandom_range(9) < 3, $urandom_range(99) < 8,
             ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(255)) << 2,
             $urandom_range(1) == 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the ARM-style CPU, directly upstream of the register file and decode.
- Owns the PC register and next-PC selection (sequential +4 or branch redirect).
- Drives a request/acknowledge read port to instruction memory and tolerates variable memory latency.
- Delivers the instruction, its PC and R15 (PC+8) to decode through an IF/ID register, with stall, flush and a one-entry hold buffer.

Parameters:
- DATA_W, 32, instruction and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- stall_i  in  1  decode cannot accept; hold IF/ID contents.
- branch_i  in  1  one-cycle redirect pulse.
- branch_target_i  in  DATA_W  redirect address; word aligned.
- imem_req_o  out  1  instruction memory read request.
- imem_addr_o  out  DATA_W  read address; stable while imem_req_o=1 and no ack.
- imem_ack_i  in  1  imem_rdata_i valid this cycle; may be asserted in the same cycle as the request.
- imem_rdata_i  in  DATA_W  fetched instruction.
- ifid_valid_o  out  1  IF/ID holds a live instruction.
- ifid_instr_o  out  DATA_W  instruction to decode (A1=[19:16], A3=[15:12]).
- ifid_pc_o  out  DATA_W  address of ifid_instr_o.
- ifid_pc_plus8_o  out  DATA_W  ifid_pc_o+8, feeds R15 input of register file.
- fetch_busy_o  out  1  memory transaction outstanding (state REQ or KILL).

Behaviour:
Reset (reset=0, asynchronous):
- pc=RESET_PC, state=IDLE, imem_req_o=0.
- ifid_valid_o=0, ifid_instr_o=0, ifid_pc_o=0, ifid_pc_plus8_o=0.
- Hold buffer is emptied.
- Reset asserted mid-transaction abandons it; any ack returned after release is ignored until a new request is issued.

States:
- IDLE: first edge after reset release -> REQ.
- REQ: imem_req_o=1, imem_addr_o=pc.
- HOLD: imem_req_o=0; a fetched instruction is parked in the hold buffer.
- KILL: imem_req_o=1, old address kept; waiting to drop stale data.

Priority in every state: branch_i > stall_i > normal progress.

REQ transitions:
- ack, no branch, (stall_i=0 or ifid_valid_o=0):
  - IF/ID <= {1, rdata, pc, pc+8}; pc <= pc+PC_STEP; stay REQ.
  - Throughput is one instruction per cycle with a zero-wait ack.
- ack, stall_i=1, ifid_valid_o=1: hold <= {rdata, pc}; pc <= pc+PC_STEP; -> HOLD.
- no ack, no branch, stall_i=1: keep requesting; IF/ID unchanged.
- branch_i with ack: rdata is dropped; pc <= target; ifid_valid_o <= 0; stay REQ (target requested next cycle).
- branch_i without ack: pc <= target; ifid_valid_o <= 0; -> KILL.

HOLD transitions:
- stall_i=0: IF/ID <= hold, valid=1; -> REQ.
- branch_i: hold dropped; pc <= target; ifid_valid_o <= 0; -> REQ.

KILL transitions:
- On ack: data discarded, IF/ID not written; -> REQ (address = new pc).
- A further branch_i while in KILL only updates pc and stays in KILL.

Flush and stall:
- Flush (branch_i) clears ifid_valid_o even while stall_i=1.
- Stall never clears valid.
- ifid_* outputs are registered; there is no combinational path from imem_rdata_i or stall_i to any ifid_* output.

Arithmetic:
- pc+PC_STEP and pc+8 are modulo 2^DATA_W; 32'hFFFF_FFFC wraps to 0.
- Low two bits of branch_target_i are forced to 0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched_o [31:0] and perf_stall_o [31:0].
  - perf_fetched_o counts instructions written into IF/ID (via REQ or from HOLD).
  - perf_stall_o counts cycles with stall_i=1 and ifid_valid_o=1.
  - Both reset to 0 and wrap at 2^32.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Release reset, ack tied 1, rdata=32'hE2811001: first request at 0x0; ifid_pc_o = 0,4,8 on consecutive cycles; ifid_pc_plus8_o=8 when ifid_pc_o=0; valid stays 1.
- Ack delayed 3 cycles per request: imem_addr_o stable during each wait; fetch_busy_o=1 throughout; IF/ID updates once every 4 cycles.
- stall_i=1 for 5 cycles with IF/ID valid (pc 0x4) and ack returning for 0x8: IF/ID holds 0x4; state HOLD, req=0; after stall drops, IF/ID shows 0x8 next edge, then request 0xC.
- branch_i with target 0x100 while a request to 0x10 is outstanding (ack 2 cycles later): valid->0; 0x10 data never reaches IF/ID; next request addr=0x100.
- branch_i with target 0x40 while stall_i=1 and HOLD occupied: hold dropped, valid=0, next request 0x40; reset pulsed mid-request: all outputs return to reset values immediately, fetch restarts at RESET_PC.
- With FETCH_PERF_CNT_EN: 10 fetches plus a 3-cycle stall -> perf_fetched_o=10, perf_stall_o=3.
